mem_stage: RTL
==============

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter ES_TO_MS_BUS_WD, default 84, width of the execute-to-memory bus.
REQ-002 Parameter MS_TO_WS_BUS_WD, default 79, width of the memory-to-writeback bus.
REQ-003 Port clk, input, 1: single clock; all state on rising edge.
REQ-004 Port reset, input, 1: asynchronous, active-high reset.
REQ-005 Port ws_allowin, input, 1: writeback accepts an instruction this cycle.
REQ-006 Port ms_allowin, output, 1: this stage accepts from execute this cycle.
REQ-007 Port es_to_ms_valid, input, 1: execute offers an instruction.
REQ-008 Port es_to_ms_bus, input, ES_TO_MS_BUS_WD: {ex[83], bd[82], eret[81], syscall[80], mfc0[79], mtc0[78], lb[77], lbu[76], lh[75], lhu[74], lw[73], lwl[72], lwr[71], res_from_mem[70], gr_we[69], dest[68:64], exe_result[63:32], pc[31:0]}.
REQ-009 Port ms_to_ws_valid, output, 1: instruction offered to writeback.
REQ-010 Port ms_to_ws_bus, output, MS_TO_WS_BUS_WD: {ex[78], bd[77], eret[76], syscall[75], mfc0[74], mtc0[73], rf_wen[72:69], dest[68:64], final_result[63:32], pc[31:0]}.
REQ-011 Port data_sram_rdata, input, 32: synchronous-SRAM read word, valid the cycle after the address was issued by execute.
REQ-012 Port ms_fwd_blk_bus, output, 42: {fwd_valid[41:38], rf_dest[37:33], rf_data[32:1], blk_valid[0]}.
REQ-013 Port ms_ex, output, 1: ms_valid & (ex | eret); suppresses stores and HI/LO writes in execute.
REQ-014 Port ms_inst_mfc0_o, output, 1: ms_valid & mfc0.
REQ-015 Ports ws_ex and eret_flush, input, 1 each: pipeline flush requests from writeback.

Function
REQ-016 ms_ready_go SHALL be 1; ms_allowin = !ms_valid | (ms_ready_go & ws_allowin).
REQ-017 On ms_allowin, ms_valid SHALL load es_to_ms_valid; bus register SHALL load es_to_ms_bus only when es_to_ms_valid & ms_allowin.
REQ-018 If ws_ex | eret_flush, ms_valid SHALL clear next edge, overriding REQ-017; ms_to_ws_valid, ms_ex, blk_valid and fwd_valid SHALL be 0 that same cycle.
REQ-019 ms_to_ws_valid = ms_valid & ms_ready_go & !ws_ex & !eret_flush.
REQ-020 Read-data buffer: on the first cycle an instruction occupies the stage (the cycle after acceptance), data_sram_rdata SHALL be captured into rbuf and rbuf_valid set; while rbuf_valid, rbuf SHALL be used instead of data_sram_rdata; rbuf_valid SHALL clear when the instruction leaves (ws_allowin) or is flushed.
REQ-021 Load extraction, a = exe_result[1:0], w = selected word: lb/lbu byte a sign/zero-extended; lh/lhu halfword a[1] sign/zero-extended; lw w; rf_wen 1111 for all these.
REQ-022 lwl: a=0 {w[7:0],24'b0} wen 1000; a=1 {w[15:0],16'b0} wen 1100; a=2 {w[23:0],8'b0} wen 1110; a=3 w wen 1111.
REQ-023 lwr: a=0 w wen 1111; a=1 {8'b0,w[31:8]} wen 0111; a=2 {16'b0,w[31:16]} wen 0011; a=3 {24'b0,w[31:24]} wen 0001.
REQ-024 Non-load: final_result = exe_result; rf_wen = {4{gr_we}}; loads with gr_we=0 or ex=1 SHALL drive rf_wen 0000.
REQ-025 fwd_valid = {4{ms_valid}} & rf_wen; rf_dest = dest; rf_data = final_result; blk_valid = ms_valid & mfc0 & !ws_ex & !eret_flush.
REQ-026 Exception fields (ex, bd, eret, syscall, mfc0, mtc0) SHALL pass unchanged to ms_to_ws_bus.

Reset
REQ-027 While reset asserts: ms_valid=0, rbuf_valid=0, bus register=0; hence ms_to_ws_valid, ms_ex, ms_inst_mfc0_o, fwd_valid, blk_valid all 0; ms_allowin=1.
REQ-028 Reset deasserted mid-load SHALL leave the stage empty; no partial result SHALL be issued.

Verification
REQ-029 lb, exe_result=0x1003, rdata=0x80FF_1234, ws_allowin=1 -> final_result 0xFFFF_FF80, rf_wen 1111, one ms_to_ws_valid cycle.
REQ-030 lwl a=1, rdata=0xAABB_CCDD -> result 0xCCDD_0000, rf_wen 1100; lwr a=2 -> 0x0000_AABB, rf_wen 0011.
REQ-031 lhu a=2, ws_allowin=0 for 3 cycles, rdata changed to 0 after cycle 1 -> result 0x0000_AABB from rbuf, ms_allowin=0 while stalled.
REQ-032 ws_ex pulse while valid add in stage -> ms_to_ws_valid 0 same cycle, ms_valid 0 next cycle, fwd_valid 0000.
REQ-033 Instruction with ex=1 -> ms_ex=1, rf_wen 0000; mfc0 dest=5 -> ms_inst_mfc0_o=1, blk_valid=1.
REQ-034 Reset asserted asynchronously mid-stall -> ms_valid=0 before next edge, ms_allowin=1.

Source files
------------

// File: rtl/mem_stage.sv
// Memory stage: holds one instruction after execute, extracts load data
// from the SRAM read word and offers the result to writeback.
module mem_stage #(
    parameter int ES_TO_MS_BUS_WD = 84,
    parameter int MS_TO_WS_BUS_WD = 79
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ws_allowin,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    input  logic [31:0]                data_sram_rdata,
    output logic [41:0]                ms_fwd_blk_bus,
    output logic                       ms_ex,
    output logic                       ms_inst_mfc0_o,
    input  logic                       ws_ex,
    input  logic                       eret_flush
);

    logic                       ms_valid;
    logic                       ms_ready_go;
    logic                       flush;
    logic [ES_TO_MS_BUS_WD-1:0] bus_r;
    logic [31:0]                rbuf;
    logic                       rbuf_valid;

    logic        ex, bd, eret, syscall, mfc0, mtc0;
    logic        lb, lbu, lh, lhu, lw, lwl, lwr;
    logic        res_from_mem, gr_we;
    logic [4:0]  dest;
    logic [31:0] exe_result, pc;

    logic [1:0]  a;
    logic [31:0] w;
    logic [31:0] w_sh;
    logic [15:0] half;
    logic [31:0] final_result;
    logic [3:0]  rf_wen;

    assign {ex, bd, eret, syscall, mfc0, mtc0,
            lb, lbu, lh, lhu, lw, lwl, lwr,
            res_from_mem, gr_we, dest, exe_result, pc} = bus_r;

    assign ms_ready_go    = 1'b1;
    assign flush          = ws_ex | eret_flush;
    assign ms_allowin     = !ms_valid | (ms_ready_go & ws_allowin);
    assign ms_to_ws_valid = ms_valid & ms_ready_go & !flush;

    // Stage occupancy and captured execute bundle; a flush empties the stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ms_valid <= 1'b0;
            bus_r    <= '0;
        end else begin
            if (flush) begin
                ms_valid <= 1'b0;
            end else if (ms_allowin) begin
                ms_valid <= es_to_ms_valid;
            end
            if (es_to_ms_valid && ms_allowin) begin
                bus_r <= es_to_ms_bus;
            end
        end
    end

    // The SRAM word is only valid for one cycle; hold it while stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rbuf_valid <= 1'b0;
            rbuf       <= '0;
        end else if (flush || ws_allowin) begin
            rbuf_valid <= 1'b0;
        end else if (ms_valid && !rbuf_valid) begin
            rbuf_valid <= 1'b1;
            rbuf       <= data_sram_rdata;
        end
    end

    assign a    = exe_result[1:0];
    assign w    = rbuf_valid ? rbuf : data_sram_rdata;
    assign w_sh = w >> {a, 3'b000};
    assign half = a[1] ? w[31:16] : w[15:0];

    // Load alignment/extension and register byte-enables.
    always_comb begin
        final_result = exe_result;
        rf_wen       = {4{gr_we}};
        if (res_from_mem) begin
            rf_wen = 4'b1111;
            if (lb) begin
                final_result = {{24{w_sh[7]}}, w_sh[7:0]};
            end else if (lbu) begin
                final_result = {24'b0, w_sh[7:0]};
            end else if (lh) begin
                final_result = {{16{half[15]}}, half};
            end else if (lhu) begin
                final_result = {16'b0, half};
            end else if (lw) begin
                final_result = w;
            end else if (lwl) begin
                case (a)
                    2'd0: begin final_result = {w[7:0], 24'b0};  rf_wen = 4'b1000; end
                    2'd1: begin final_result = {w[15:0], 16'b0}; rf_wen = 4'b1100; end
                    2'd2: begin final_result = {w[23:0], 8'b0};  rf_wen = 4'b1110; end
                    default: begin final_result = w;             rf_wen = 4'b1111; end
                endcase
            end else if (lwr) begin
                case (a)
                    2'd0: begin final_result = w;                 rf_wen = 4'b1111; end
                    2'd1: begin final_result = {8'b0, w[31:8]};   rf_wen = 4'b0111; end
                    2'd2: begin final_result = {16'b0, w[31:16]}; rf_wen = 4'b0011; end
                    default: begin final_result = {24'b0, w[31:24]}; rf_wen = 4'b0001; end
                endcase
            end
        end
        if (ex || (res_from_mem && !gr_we)) begin
            rf_wen = 4'b0000;
        end
    end

    assign ms_to_ws_bus = {ex, bd, eret, syscall, mfc0, mtc0,
                           rf_wen, dest, final_result, pc};

    assign ms_fwd_blk_bus = {{4{ms_valid & !flush}} & rf_wen,
                             dest, final_result,
                             ms_valid & mfc0 & !flush};

    assign ms_ex          = ms_valid & (ex | eret) & !flush;
    assign ms_inst_mfc0_o = ms_valid & mfc0;

endmodule
